ysq_acc_alu: RTL

- Parametrised successor of the accumulator/arithmetic unit in the DJS-130 datapath.
- Holds NACC accumulators of W bits plus a carry flag, and executes Nova-style ALU instructions (function, carry base, shift, skip, no-load) in one cycle.
- Adds an iterative multiply/divide sequencer, replacing the separate storage/multiply block, with a busy (wait) output for the control unit.
- Fully synchronous to one clock: register loads are enables, not per-register strobe clocks.

---
 rtl/ysq_acc_alu_pkg.sv | 38 +++
 rtl/ysq_acc_alu_if.sv | 40 ++++
 rtl/ysq_acc_alu_mdv_seq.sv | 93 +++++++++
 rtl/ysq_acc_alu.sv | 138 +++++++++++++
 4 files changed

// File: rtl/ysq_acc_alu_pkg.sv
// Shared types for the accumulator/ALU block: instruction field encodings,
// multiply/divide sequencer states and the skip-condition evaluator.
package ysq_pkg;

  typedef enum logic [2:0] {
    FN_COM, FN_NEG, FN_MOV, FN_INC, FN_ADC, FN_SUB, FN_ADD, FN_AND
  } func_e;

  typedef enum logic [1:0] {CB_KEEP, CB_ZERO, CB_ONE, CB_COMP} cbase_e;

  typedef enum logic [1:0] {SH_NONE, SH_LEFT, SH_RIGHT, SH_SWAP} shift_e;

  typedef enum logic [2:0] {
    SK_NEVER, SK_ALWAYS, SK_SZC, SK_SNC, SK_SZR, SK_SNR, SK_SEZ, SK_SBN
  } skip_e;

  typedef enum logic {MDV_MUL, MDV_DIV} mdv_op_e;

  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_e;

  // Skip decision from the post-shift carry and a zero flag of the post-shift result.
  function automatic logic skip_eval(input skip_e code, input logic cs, input logic rs_zero);
    logic hit;
    hit = 1'b0;
    case (code)
      SK_NEVER:  hit = 1'b0;
      SK_ALWAYS: hit = 1'b1;
      SK_SZC:    hit = !cs;
      SK_SNC:    hit = cs;
      SK_SZR:    hit = rs_zero;
      SK_SNR:    hit = !rs_zero;
      SK_SEZ:    hit = !cs | rs_zero;
      default:   hit = cs & !rs_zero;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/ysq_acc_alu_if.sv
// Request/response bus between the control unit (master) and the accumulator/ALU block (slave).
interface ysq_acc_alu_if #(
  parameter int W  = 16,
  parameter int AW = 2
);
  logic          i_op_valid;
  logic          o_op_ready;
  logic [2:0]    i_func;
  logic [AW-1:0] i_src;
  logic [AW-1:0] i_dst;
  logic [1:0]    i_cbase;
  logic [1:0]    i_shift;
  logic [2:0]    i_skip;
  logic          i_noload;
  logic          i_ld_valid;
  logic [AW-1:0] i_ld_acc;
  logic [W-1:0]  i_ld_data;
  logic          o_ld_ready;
  logic          i_mdv_start;
  logic          i_mdv_op;
  logic [AW-1:0] i_rd_sel;
  logic [W-1:0]  o_rd_data;
  logic [W-1:0]  o_MX;
  logic          o_Cj;
  logic          o_skip;
  logic          o_done;
  logic          o_DD;

  modport master (
    output i_op_valid, i_func, i_src, i_dst, i_cbase, i_shift, i_skip, i_noload,
           i_ld_valid, i_ld_acc, i_ld_data, i_mdv_start, i_mdv_op, i_rd_sel,
    input  o_op_ready, o_ld_ready, o_rd_data, o_MX, o_Cj, o_skip, o_done, o_DD
  );

  modport slave (
    input  i_op_valid, i_func, i_src, i_dst, i_cbase, i_shift, i_skip, i_noload,
           i_ld_valid, i_ld_acc, i_ld_data, i_mdv_start, i_mdv_op, i_rd_sel,
    output o_op_ready, o_ld_ready, o_rd_data, o_MX, o_Cj, o_skip, o_done, o_DD
  );
endinterface

// File: rtl/ysq_acc_alu_mdv_seq.sv
// Iterative unsigned multiply (shift-add, AC1*AC2+AC0) and restoring divide ({AC0,AC1}/AC2),
// one bit per cycle; results are presented to the top for writing during DONE.
module ysq_mdv_seq
  import ysq_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk_mdv,
  input  logic         rst_n,
  input  logic         start,
  input  mdv_op_e      op,
  input  logic [W-1:0] ac0,
  input  logic [W-1:0] ac1,
  input  logic [W-1:0] ac2,
  output logic         busy,
  output logic         done,
  output logic         wr_acc,
  output logic         wr_carry,
  output logic         carry_val,
  output logic [W-1:0] res_hi,
  output logic [W-1:0] res_lo
);
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  seq_state_e    state_q, state_d;
  mdv_op_e       op_q;
  logic          ovf_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  hi_q, lo_q, dvs_q, hi_n, lo_n, div_diff;
  logic [W:0]    mul_sum, div_t;
  logic          div_ge;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (ovf_q || cnt_q == LAST) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Multiply keeps the running high half in hi_q and shifts product bits into lo_q as the
  // multiplier drains; divide shifts the dividend left through hi_q (partial remainder).
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : {(W+1){1'b0}});
    div_t    = {hi_q, lo_q[W-1]};
    div_ge   = div_t >= {1'b0, dvs_q};
    div_diff = div_t[W-1:0] - dvs_q;
    if (op_q == MDV_MUL) begin
      hi_n = mul_sum[W:1];
      lo_n = {mul_sum[0], lo_q[W-1:1]};
    end else begin
      hi_n = div_ge ? div_diff : div_t[W-1:0];
      lo_n = {lo_q[W-2:0], div_ge};
    end
  end

  always_ff @(posedge clk_mdv or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= MDV_MUL;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dvs_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        op_q  <= op;
        ovf_q <= (op == MDV_DIV) && (ac0 >= ac2);
        cnt_q <= '0;
        hi_q  <= ac0;
        lo_q  <= ac1;
        dvs_q <= ac2;
      end else if (state_q == RUN && !ovf_q) begin
        hi_q  <= hi_n;
        lo_q  <= lo_n;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign wr_acc    = done & !ovf_q;
  assign wr_carry  = done & (op_q == MDV_DIV);
  assign carry_val = ovf_q;
  assign res_hi    = hi_q;
  assign res_lo    = lo_q;

endmodule

// File: rtl/ysq_acc_alu.sv
// Accumulator file, carry flag and single-cycle Nova-style ALU/shifter/skip unit,
// with an optional iterative multiply/divide sequencer that stalls the bus while busy.
module ysq_acc_alu
  import ysq_pkg::*;
#(
  parameter int W      = 16,
  parameter int NACC   = 4,
  parameter int MDV_EN = 1
) (
  input  logic           clk_mdv,
  input  logic           rst_n,
  ysq_acc_alu_if.slave   bus
);
  localparam int   HW     = W / 2;
  localparam logic MDV_ON = (MDV_EN != 0);

  logic [W-1:0] acc [NACC];
  logic         carry, skip_q, done_q;
  logic [W-1:0] mx_q;
  logic         busy, mdv_req, mdv_go, op_ready, ld_ready, op_fire, ld_fire;
  logic         mdv_done, mdv_wr_acc, mdv_wr_carry, mdv_carry;
  logic [W-1:0] mdv_hi, mdv_lo;
  logic [W-1:0] s_val, d_val, r_val, rs;
  logic [W:0]   sum;
  logic         cb, c_int, cs, skip_hit;

  // Priority: multiply/divide start, then ALU op, then load.
  assign mdv_req  = bus.i_mdv_start & MDV_ON;
  assign mdv_go   = mdv_req & !busy;
  assign op_ready = !busy & !mdv_req;
  assign ld_ready = !busy & !bus.i_op_valid & !mdv_req;
  assign op_fire  = bus.i_op_valid & op_ready;
  assign ld_fire  = bus.i_ld_valid & ld_ready;

  generate
    if (MDV_EN != 0) begin : g_mdv
      ysq_mdv_seq #(.W(W)) u_seq (
        .clk_mdv   (clk_mdv),
        .rst_n     (rst_n),
        .start     (mdv_go),
        .op        (mdv_op_e'(bus.i_mdv_op)),
        .ac0       (acc[0]),
        .ac1       (acc[1]),
        .ac2       (acc[2]),
        .busy      (busy),
        .done      (mdv_done),
        .wr_acc    (mdv_wr_acc),
        .wr_carry  (mdv_wr_carry),
        .carry_val (mdv_carry),
        .res_hi    (mdv_hi),
        .res_lo    (mdv_lo)
      );
    end else begin : g_no_mdv
      assign busy         = 1'b0;
      assign mdv_done     = 1'b0;
      assign mdv_wr_acc   = 1'b0;
      assign mdv_wr_carry = 1'b0;
      assign mdv_carry    = 1'b0;
      assign mdv_hi       = '0;
      assign mdv_lo       = '0;
    end
  endgenerate

  // The function result carries its own carry-out in sum[W]; it toggles the base carry.
  always_comb begin
    s_val = acc[bus.i_src];
    d_val = acc[bus.i_dst];
    case (cbase_e'(bus.i_cbase))
      CB_KEEP: cb = carry;
      CB_ZERO: cb = 1'b0;
      CB_ONE:  cb = 1'b1;
      default: cb = !carry;
    endcase
    case (func_e'(bus.i_func))
      FN_COM:  sum = {1'b0, ~s_val};
      FN_NEG:  sum = {1'b0, ~s_val} + {{W{1'b0}}, 1'b1};
      FN_MOV:  sum = {1'b0, s_val};
      FN_INC:  sum = {1'b0, s_val} + {{W{1'b0}}, 1'b1};
      FN_ADC:  sum = {1'b0, ~s_val} + {1'b0, d_val};
      FN_SUB:  sum = {1'b0, ~s_val} + {1'b0, d_val} + {{W{1'b0}}, 1'b1};
      FN_ADD:  sum = {1'b0, s_val} + {1'b0, d_val};
      default: sum = {1'b0, s_val & d_val};
    endcase
    c_int = cb ^ sum[W];
    r_val = sum[W-1:0];
    case (shift_e'(bus.i_shift))
      SH_LEFT:  {cs, rs} = {r_val, c_int};
      SH_RIGHT: {cs, rs} = {r_val[0], c_int, r_val[W-1:1]};
      SH_SWAP:  {cs, rs} = {c_int, r_val[HW-1:0], r_val[W-1:HW]};
      default:  {cs, rs} = {c_int, r_val};
    endcase
  end

  assign skip_hit = skip_eval(skip_e'(bus.i_skip), cs, rs == '0);

  always_ff @(posedge clk_mdv or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NACC; i++) acc[i] <= '0;
      carry  <= 1'b0;
      mx_q   <= '0;
      skip_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (mdv_done) begin
        done_q <= 1'b1;
        skip_q <= 1'b0;
        if (mdv_wr_acc) begin
          acc[0] <= mdv_hi;
          acc[1] <= mdv_lo;
        end
        if (mdv_wr_carry) carry <= mdv_carry;
      end else if (op_fire) begin
        done_q <= 1'b1;
        skip_q <= skip_hit;
        mx_q   <= rs;
        if (!bus.i_noload) begin
          acc[bus.i_dst] <= rs;
          carry          <= cs;
        end
      end else if (ld_fire) begin
        done_q             <= 1'b1;
        skip_q             <= 1'b0;
        acc[bus.i_ld_acc]  <= bus.i_ld_data;
      end
    end
  end

  assign bus.o_op_ready = op_ready;
  assign bus.o_ld_ready = ld_ready;
  assign bus.o_rd_data  = acc[bus.i_rd_sel];
  assign bus.o_MX       = mx_q;
  assign bus.o_Cj       = carry;
  assign bus.o_skip     = skip_q;
  assign bus.o_done     = done_q;
  assign bus.o_DD       = busy;

endmodule
